// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: FETCH -> WAIT -> EXEC loop with a fetch timeout and misaligned-PC fault.
// Optional retired-instruction counter enabled by defining FETCH_PERF_COUNT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        retire,
  input  logic [31:0] pc_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        fault_q;
  logic [1:0]  fault_cause_q;
  logic [7:0]  tmo_q;
  logic        retire_ok;

  // Request is combinational on stall so a released stall issues in the same cycle.
  assign imem_req    = (state_q == S_FETCH) && !stall && !rst;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign retire_ok   = (state_q == S_EXEC) && retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
      tmo_q         <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_req && imem_gnt) begin
            state_q <= S_WAIT;
            tmo_q   <= '0;
          end
        end
        S_WAIT: begin
          // Data arriving on the last allowed cycle still wins over the timeout.
          if (imem_rvalid) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= S_EXEC;
          end else if (tmo_q == TMO_LAST) begin
            state_q       <= S_HALT;
            fault_q       <= 1'b1;
            fault_cause_q <= 2'b10;
          end else if (tmo_q != 8'hFF) begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_EXEC: begin
          if (retire) begin
            instr_valid_q <= 1'b0;
            if (pc_n[1:0] != 2'b00) begin
              state_q       <= S_HALT;
              fault_q       <= 1'b1;
              fault_cause_q <= 2'b01;
            end else begin
              pc_q    <= pc_n;
              state_q <= S_FETCH;
            end
          end
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] retire_count_q;

  // Misaligned retires still count: the instruction itself completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count_q <= '0;
    end else if (retire_ok) begin
      retire_count_q <= retire_count_q + 32'd1;
    end
  end

  assign retire_count = retire_count_q;
`else
  logic unused_retire_ok;
  assign unused_retire_ok = retire_ok;
  assign retire_count     = 32'd0;
`endif

endmodule
